// File: rtl/lstm_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// lstm_seq_ctrl_if
// Bundles the handshake, cell-feedback and memory-address signals of the
// LSTM timestep sequencer so that the sequencer and its environment connect
// through a single port.
//
// Signals
//   i_start      start a sequence (sampled only while idle)
//   i_hold       freeze sequencing for the current cycle
//   i_c, i_h     cell outputs c(t) / h(t)
//   o_acc_x      cell accumulate-input strobe
//   o_acc_h      cell accumulate-hidden strobe
//   o_x_addr     input-sample memory address
//   o_k          current term index (weight memory select)
//   o_h_rd_addr  hidden buffer read address {bank, k}
//   o_prev_state c(t-1) fed back to the cell
//   o_h_wr_en    hidden buffer write strobe
//   o_h_wr_addr  hidden buffer write address {bank, cell index}
//   o_h_wr_data  captured h(t)
//   o_t          current timestep
//   o_busy       sequencer not idle
//   o_done       end-of-sequence pulse
//
// Modports
//   master : the sequencer (drives the o_* signals)
//   slave  : the environment (drives the i_* signals)
// ---------------------------------------------------------------------------
interface lstm_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int XA_W  = 8,
    parameter int HA_W  = 4,
    parameter int T_W   = 5
);
    logic              i_start;
    logic              i_hold;
    logic [WIDTH-1:0]  i_c;
    logic [WIDTH-1:0]  i_h;
    logic              o_acc_x;
    logic              o_acc_h;
    logic [XA_W-1:0]   o_x_addr;
    logic [HA_W-1:0]   o_k;
    logic [HA_W:0]     o_h_rd_addr;
    logic [WIDTH-1:0]  o_prev_state;
    logic              o_h_wr_en;
    logic [HA_W:0]     o_h_wr_addr;
    logic [WIDTH-1:0]  o_h_wr_data;
    logic [T_W-1:0]    o_t;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start, i_hold, i_c, i_h,
        output o_acc_x, o_acc_h, o_x_addr, o_k, o_h_rd_addr, o_prev_state,
               o_h_wr_en, o_h_wr_addr, o_h_wr_data, o_t, o_busy, o_done
    );

    modport slave (
        output i_start, i_hold, i_c, i_h,
        input  o_acc_x, o_acc_h, o_x_addr, o_k, o_h_rd_addr, o_prev_state,
               o_h_wr_en, o_h_wr_addr, o_h_wr_data, o_t, o_busy, o_done
    );
endinterface

// File: rtl/lstm_seq_ctrl.sv
// ---------------------------------------------------------------------------
// lstm_seq_ctrl
// Timestep sequencer for a single LSTM cell. Per timestep it streams NUM_X
// input terms (acc_x) and, from t=1 onward, NUM_H recurrent terms (acc_h),
// waits LAT cycles for the cell pipeline, then captures c(t) as the next
// prev_state and h(t) for the double-banked hidden buffer.
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  lstm_seq_ctrl_if.master (start/hold, cell feedback, addresses,
//        write port, status)
// ---------------------------------------------------------------------------
module lstm_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int NUM_X   = 8,
    parameter int NUM_H   = 8,
    parameter int TSTEPS  = 16,
    parameter int LAT     = 3,
    parameter int CELL_ID = 0,
    parameter int XA_W    = 8,
    parameter int HA_W    = 4,
    parameter int T_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    lstm_seq_ctrl_if.master  bus
);

    localparam int W_W = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC_X = 3'd1,
        ST_ACC_H = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CAPT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;

    logic [T_W-1:0]    t_r;
    logic [HA_W-1:0]   k_r;
    logic [W_W-1:0]    wait_r;
    logic [XA_W-1:0]   x_addr_r;
    logic [WIDTH-1:0]  prev_state_r;
    logic [WIDTH-1:0]  wr_data_r;
    logic [HA_W:0]     wr_addr_r;
    logic              wr_en_r;

    logic              adv_s;
    logic              k_last_x_s;
    logic              k_last_h_s;
    logic              wait_last_s;
    logic              t_first_s;
    logic              t_last_s;

    // Terminal-count decodes shared by the FSM and the counters.
    always_comb begin
        adv_s       = ~bus.i_hold;
        k_last_x_s  = (k_r == HA_W'(NUM_X - 1));
        k_last_h_s  = (k_r == HA_W'(NUM_H - 1));
        wait_last_s = (wait_r == W_W'(LAT - 1));
        t_first_s   = (t_r == T_W'(0));
        t_last_s    = (t_r == T_W'(TSTEPS - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; every non-idle transition is gated by hold.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_nxt_s = ST_ACC_X;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC_X: begin
                if (adv_s && k_last_x_s) begin
                    // h(-1) is zero, so the first timestep has no recurrent terms.
                    state_nxt_s = t_first_s ? ST_WAIT : ST_ACC_H;
                end else begin
                    state_nxt_s = ST_ACC_X;
                end
            end
            ST_ACC_H: begin
                if (adv_s && k_last_h_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_ACC_H;
                end
            end
            ST_WAIT: begin
                if (adv_s && wait_last_s) begin
                    state_nxt_s = ST_CAPT;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_CAPT: begin
                if (adv_s) begin
                    state_nxt_s = t_last_s ? ST_DONE : ST_ACC_X;
                end else begin
                    state_nxt_s = ST_CAPT;
                end
            end
            ST_DONE: begin
                if (adv_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencing counters and capture registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t_r          <= T_W'(0);
            k_r          <= HA_W'(0);
            wait_r       <= W_W'(0);
            x_addr_r     <= XA_W'(0);
            prev_state_r <= WIDTH'(0);
            wr_data_r    <= WIDTH'(0);
            wr_addr_r    <= (HA_W + 1)'(0);
            wr_en_r      <= 1'b0;
        end else begin
            // Write strobe follows a non-held capture cycle by exactly one cycle.
            wr_en_r <= (state_r == ST_CAPT) && adv_s;
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        t_r          <= T_W'(0);
                        k_r          <= HA_W'(0);
                        wait_r       <= W_W'(0);
                        x_addr_r     <= XA_W'(0);
                        prev_state_r <= WIDTH'(0);
                    end else begin
                        t_r <= t_r;
                    end
                end
                ST_ACC_X: begin
                    if (adv_s) begin
                        // x address runs on continuously, equal to t*NUM_X + k.
                        x_addr_r <= x_addr_r + XA_W'(1);
                        k_r      <= k_last_x_s ? HA_W'(0) : (k_r + HA_W'(1));
                    end else begin
                        k_r <= k_r;
                    end
                end
                ST_ACC_H: begin
                    if (adv_s) begin
                        k_r <= k_last_h_s ? HA_W'(0) : (k_r + HA_W'(1));
                    end else begin
                        k_r <= k_r;
                    end
                end
                ST_WAIT: begin
                    if (adv_s) begin
                        wait_r <= wait_last_s ? W_W'(0) : (wait_r + W_W'(1));
                    end else begin
                        wait_r <= wait_r;
                    end
                end
                ST_CAPT: begin
                    if (adv_s) begin
                        prev_state_r <= bus.i_c;
                        wr_data_r    <= bus.i_h;
                        // Write bank is t[0] of the timestep being captured.
                        wr_addr_r    <= {t_r[0], HA_W'(CELL_ID)};
                        k_r          <= HA_W'(0);
                        if (!t_last_s) begin
                            t_r <= t_r + T_W'(1);
                        end else begin
                            t_r <= t_r;
                        end
                    end else begin
                        t_r <= t_r;
                    end
                end
                ST_DONE: begin
                    t_r <= t_r;
                end
                default: begin
                    t_r <= t_r;
                end
            endcase
        end
    end

    // Output decode. The accumulate strobes are gated by hold in the same
    // cycle so the cell never accumulates a term whose counter is frozen.
    always_comb begin
        bus.o_acc_x      = (state_r == ST_ACC_X) && adv_s;
        bus.o_acc_h      = (state_r == ST_ACC_H) && adv_s;
        bus.o_busy       = (state_r != ST_IDLE);
        bus.o_done       = (state_r == ST_DONE) && adv_s;
        bus.o_x_addr     = x_addr_r;
        bus.o_k          = k_r;
        bus.o_t          = t_r;
        bus.o_prev_state = prev_state_r;
        bus.o_h_wr_en    = wr_en_r;
        bus.o_h_wr_addr  = wr_addr_r;
        bus.o_h_wr_data  = wr_data_r;
        // Read the bank written during the previous timestep.
        if (state_r != ST_IDLE) begin
            bus.o_h_rd_addr = {~t_r[0], k_r};
        end else begin
            bus.o_h_rd_addr = (HA_W + 1)'(0);
        end
    end

endmodule
